// File: rtl/ps_setpoint_coef_sequencer_pkg.sv
// Shared types for the setpoint coefficient write sequencer:
// table encodings, queued-write entry and timing defaults.
package ps_setpoint_coef_sequencer_pkg;

    localparam logic [1:0] TBL_GAIN      = 2'd0;
    localparam logic [1:0] TBL_FFB_CLIP  = 2'd1;
    localparam logic [1:0] TBL_PS_OFFSET = 2'd2;
    localparam logic [1:0] TBL_PS_CLIP   = 2'd3;

    localparam int ENTRY_ADDR_W = 5;
    localparam int ENTRY_DATA_W = 32;

    localparam int DEF_BUSY_CYCLES  = 32;
    localparam int DEF_IDLE_TIMEOUT = 65535;

    typedef struct packed {
        logic [1:0]              tbl;
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_DATA_W-1:0] data;
    } coef_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DRAIN
    } seq_state_t;

endpackage

// File: rtl/ps_setpoint_coef_sequencer_fifo.sv
// coef_write_fifo: synchronous FIFO with occupancy count; a push and
// pop in the same cycle are both honoured even when full.
module coef_write_fifo #(
    parameter int W     = 39,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          wr;
    logic          rd;

    assign full = (count == CW'(DEPTH));
    assign rd   = pop && (count != '0);
    assign wr   = push && (!full || rd);
    assign dout = mem[rptr];

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            unique case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ps_setpoint_coef_sequencer.sv
// Frame-aligned coefficient write sequencer. Define
// PS_SETPOINT_COEF_BATCH_EN to enable hostHold batch staging.
module ps_setpoint_coef_sequencer
    import ps_setpoint_coef_sequencer_pkg::*;
#(
    parameter int RESULT_COUNT       = 24,
    parameter int RESULT_COUNT_WIDTH = (RESULT_COUNT > 1) ? $clog2(RESULT_COUNT) : 1,
    parameter int DBUS_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 16,
    parameter int BUSY_CYCLES        = DEF_BUSY_CYCLES,
    parameter int IDLE_TIMEOUT       = DEF_IDLE_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hostWriteStrobe,
    input  logic [1:0]                    hostTable,
    input  logic [RESULT_COUNT_WIDTH-1:0] hostAddress,
    input  logic [DBUS_WIDTH-1:0]         hostData,
    input  logic                          hostHold,
    input  logic                          dinToggle,
    input  logic                          statusClear,
    output logic                          gainWriteStrobe,
    output logic                          ffbClipWriteStrobe,
    output logic                          psOffsetWriteStrobe,
    output logic                          psClipWriteStrobe,
    output logic [RESULT_COUNT_WIDTH-1:0] writeAddress,
    output logic [DBUS_WIDTH-1:0]         writeData,
    output logic                          fifoFull,
    output logic [$clog2(FIFO_DEPTH):0]   pendingCount,
    output logic                          overflow,
    output logic                          tornFrame
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BUSY_CYCLES + 1);
    localparam int QW = $clog2(IDLE_TIMEOUT + 1);

    seq_state_t    state;
    seq_state_t    state_next;
    logic          toggle_q;
    logic          frame_edge;
    logic [BW-1:0] busy_count;
    logic [QW-1:0] quiet_count;
    logic [CW-1:0] committed;
    logic [CW-1:0] committed_next;
    logic          push_ok;
    logic          pop;
    logic          go;
    logic          torn_set;
    logic          ovf_set;
    coef_entry_t   wr_entry;
    coef_entry_t   head;

    assign frame_edge = dinToggle ^ toggle_q;
    assign push_ok    = hostWriteStrobe && (!fifoFull || pop);
    assign ovf_set    = hostWriteStrobe && fifoFull && !pop;
    assign go         = !frame_edge
                        && ((busy_count == BW'(1))
                        || (quiet_count == QW'(IDLE_TIMEOUT) && busy_count == '0));

    assign wr_entry.tbl  = hostTable;
    assign wr_entry.addr = ENTRY_ADDR_W'(hostAddress);
    assign wr_entry.data = ENTRY_DATA_W'(hostData);

    coef_write_fifo #(
        .W     ($bits(coef_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .din   (wr_entry),
        .pop   (pop),
        .dout  (head),
        .count (pendingCount),
        .full  (fifoFull)
    );

`ifdef PS_SETPOINT_COEF_BATCH_EN
    logic hold_q;

    // Releasing hold commits everything queued, staged or not.
    always_comb begin
        committed_next = committed + CW'(push_ok && !hostHold) - CW'(pop);
        if (hold_q && !hostHold)
            committed_next = pendingCount + CW'(push_ok) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) hold_q <= 1'b0;
        else       hold_q <= hostHold;
    end
`else
    logic unused_hold;
    assign unused_hold = hostHold;

    always_comb begin
        committed_next = committed + CW'(push_ok) - CW'(pop);
    end
`endif

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        torn_set   = 1'b0;
        unique case (state)
            ST_IDLE, ST_ARMED: begin
                if (committed == '0) begin
                    state_next = ST_IDLE;
                end else if (go) begin
                    pop        = 1'b1;
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_ARMED;
                end
            end
            ST_DRAIN: begin
                if (committed == '0) begin
                    state_next = ST_IDLE;
                end else if (frame_edge) begin
                    torn_set   = 1'b1;
                    state_next = ST_ARMED;
                end else begin
                    pop = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= ST_IDLE;
            toggle_q            <= dinToggle;
            busy_count          <= '0;
            quiet_count         <= '0;
            committed           <= '0;
            gainWriteStrobe     <= 1'b0;
            ffbClipWriteStrobe  <= 1'b0;
            psOffsetWriteStrobe <= 1'b0;
            psClipWriteStrobe   <= 1'b0;
            writeAddress        <= '0;
            writeData           <= '0;
            overflow            <= 1'b0;
            tornFrame           <= 1'b0;
        end else begin
            state     <= state_next;
            toggle_q  <= dinToggle;
            committed <= committed_next;
            if (frame_edge)              busy_count <= BW'(BUSY_CYCLES);
            else if (busy_count != '0)   busy_count <= busy_count - 1'b1;
            if (frame_edge)              quiet_count <= '0;
            else if (quiet_count != QW'(IDLE_TIMEOUT))
                quiet_count <= quiet_count + 1'b1;
            gainWriteStrobe     <= pop && (head.tbl == TBL_GAIN);
            ffbClipWriteStrobe  <= pop && (head.tbl == TBL_FFB_CLIP);
            psOffsetWriteStrobe <= pop && (head.tbl == TBL_PS_OFFSET);
            psClipWriteStrobe   <= pop && (head.tbl == TBL_PS_CLIP);
            if (pop) begin
                writeAddress <= RESULT_COUNT_WIDTH'(head.addr);
                writeData    <= DBUS_WIDTH'(head.data);
            end
            overflow  <= ovf_set || (overflow && !statusClear);
            tornFrame <= torn_set || (tornFrame && !statusClear);
        end
    end

endmodule

// File: doc/ps_setpoint_coef_sequencer.md
# ps_setpoint_coef_sequencer

Frame-aligned coefficient write sequencer for the power-supply setpoint calculation pipeline. It queues host writes to the four per-channel tables (gain, FFB clip, PS offset, PS clip). It releases them onto the pipeline's single shared write port only in the quiet window between FIR result frames, so no frame is computed with a half-updated coefficient set. It sits between the CSR decode and the setpoint calculation block and watches the same `dinToggle` that starts each frame.

## Interface
- `RESULT_COUNT`, 24: channels per table.
- `RESULT_COUNT_WIDTH`, `$clog2(RESULT_COUNT)` (1 if `RESULT_COUNT`==1): channel address width.
- `DBUS_WIDTH`, 32: data width.
- `FIFO_DEPTH`, 16: queued writes, power of two.
- `BUSY_CYCLES`, 32: cycles after a `dinToggle` edge during which the pipeline reads tables. Must be ≥ `RESULT_COUNT`+8.
- `IDLE_TIMEOUT`, 65535: cycles without a frame after which queued writes drain unaligned.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `hostWriteStrobe` in 1: enqueue one write.
- `hostTable` in 2: 0 gain, 1 ffbClip, 2 psOffset, 3 psClip.
- `hostAddress` in `RESULT_COUNT_WIDTH`: channel.
- `hostData` in `DBUS_WIDTH`: value.
- `hostHold` in 1: batch staging (see Configuration).
- `dinToggle` in 1: frame-start toggle, same net the pipeline sees.
- `statusClear` in 1: clears sticky flags.
- `gainWriteStrobe`, `ffbClipWriteStrobe`, `psOffsetWriteStrobe`, `psClipWriteStrobe` out 1: one-hot table strobes.
- `writeAddress` out `RESULT_COUNT_WIDTH`, `writeData` out `DBUS_WIDTH`: shared write bus.
- `fifoFull` out 1; `pendingCount` out `$clog2(FIFO_DEPTH)+1`.
- `overflow` out 1: sticky, a write was dropped.
- `tornFrame` out 1: sticky, a frame edge interrupted a drain.

## Operation
- Frame tracking: `toggleQ` registers `dinToggle`; `edge` = `dinToggle`≠`toggleQ`. On `edge`, `busyCount` loads `BUSY_CYCLES`; otherwise it decrements while nonzero. `quietCount` clears on `edge`, else increments and saturates at `IDLE_TIMEOUT`.
- FIFO: entries are {table, address, data}. A write when full is dropped and sets `overflow`. A simultaneous push and pop while full is accepted. `committed` counts entries eligible for drain, always ≤ occupancy.
- States:
  - IDLE: `committed`==0. Go to ARMED when `committed`>0.
  - ARMED:
    - Go to DRAIN when `busyCount`==1 and no `edge`.
    - Also go to DRAIN when `quietCount`==`IDLE_TIMEOUT` and `busyCount`==0.
  - DRAIN: each cycle with no `edge` and `committed`>0, pop one entry and decrement `committed`.
    - `edge` in DRAIN: no pop that cycle, set `tornFrame`, go to ARMED.
    - `committed`==0: go to IDLE.
- Outputs are registered. A popped entry drives its strobe (exactly one high), `writeAddress` and `writeData` for one cycle. When no entry is popped, all strobes are 0 and the bus holds its last value.
- Drain order is strictly FIFO. Multiple writes to the same table and channel all issue, so the last one wins.

## Timing
- Reset values: all strobes 0, `writeAddress` 0, `writeData` 0, `overflow` 0, `tornFrame` 0, `fifoFull` 0, `pendingCount` 0. State is IDLE, FIFO flushed, `busyCount` 0, `quietCount` 0, `toggleQ` = `dinToggle`.
- Reset mid-drain: strobes are 0 on the cycle after `reset` is sampled high; queued entries are lost.
- Pop to strobe latency is 1 cycle. With an `edge` at cycle E, the first strobe is at E+`BUSY_CYCLES`+1, then one strobe per cycle.
- System requirement: frame period ≥ `BUSY_CYCLES`+`FIFO_DEPTH`+1, so a full batch lands in one window. Violating it is reported by `tornFrame`, not prevented.
- `statusClear` together with a new set event: the set wins.

## Configuration
- `PS_SETPOINT_COEF_BATCH_EN` defined:
  - Writes enqueued while `hostHold`=1 are staged and not committed.
  - On the `hostHold` falling edge, `committed` is set to occupancy, so the whole batch drains within one window.
  - Writes with `hostHold`=0 commit on enqueue.
- Undefined: `hostHold` is ignored and every write commits on enqueue.

## Structure
- Shared package holds:
  - table-select encoding constants (GAIN, FFB_CLIP, PS_OFFSET, PS_CLIP);
  - the FIFO entry typedef;
  - `BUSY_CYCLES`/`IDLE_TIMEOUT` defaults.
- One sub-module: `coef_write_fifo`, a synchronous FIFO with occupancy output. The state machine and frame tracking stay in the top level.

## Test plan
- Toggle at cycle 100, write (gain, ch 5, 0x1234) at cycle 110 → `gainWriteStrobe` at cycle 133 only, with `writeAddress`=5 and `writeData`=0x1234.
- No toggles, one psClip write, `IDLE_TIMEOUT`=200 → strobe 201–202 cycles after reset release; never earlier.
- Batch (BATCH_EN): `hostHold`=1, 24 offset writes, `hostHold` falls, then toggle → 24 consecutive `psOffsetWriteStrobe` cycles in order 0..23, no strobe before the window.
- 17 writes with depth 16 during busy → `overflow`=1, 16 strobes issued, 17th absent; `statusClear` → `overflow`=0.
- Frame period 40 with 16 committed writes → edge mid-drain: `tornFrame`=1, remaining writes issue in the next window, none during busy.
- `reset` asserted mid-drain → strobes 0 next cycle, `pendingCount`=0, no further strobes after the next toggle.
